pong_ball_engine: RTL and testbench

PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

---
 rtl/pong_pkg.sv | 50 +++++
 rtl/pong_ball_collide.sv | 82 ++++++++
 rtl/pong_ball_engine.sv | 170 +++++++++++++++++
 tb/tb_pong_ball_engine.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants, state encoding and ball payload for the pong ball engine.
// Holds default screen/paddle/ball/score geometry, the FSM state enum, the
// ball state struct and small helpers (step decode, saturating BCD increment).
package pong_pkg;

  // Default geometry; the engine exposes these as overridable parameters.
  localparam int unsigned DFLT_SCREEN_W    = 1024;
  localparam int unsigned DFLT_SCREEN_H    = 768;
  localparam int unsigned DFLT_BALL_SIZE   = 16;
  localparam int unsigned DFLT_PADDLE_W    = 16;
  localparam int unsigned DFLT_PADDLE_H    = 128;
  localparam int unsigned DFLT_LEFT_X      = 32;
  localparam int unsigned DFLT_RIGHT_X     = 976;
  localparam int unsigned DFLT_WIN_SCORE   = 9;
  localparam int unsigned DFLT_GOAL_FRAMES = 60;

  localparam int unsigned POS_W   = 11;
  localparam int unsigned CALC_W  = 12;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned STEP_W  = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_MOVE  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Ball position (top-left) and direction; *_neg = 1 means moving toward 0.
  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             dx_neg;
    logic             dy_neg;
  } ball_t;

  // speed_selector 0..3 -> 2/4/6/8 px per tick.
  function automatic logic [STEP_W-1:0] step_px(input logic [1:0] sel);
    return {1'b0, sel, 1'b0} + 4'd2;
  endfunction

  // One BCD digit, saturating at 9.
  function automatic logic [SCORE_W-1:0] bcd_sat_inc(input logic [SCORE_W-1:0] v);
    return (v >= SCORE_MAX) ? SCORE_MAX : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_ball_collide.sv
// Combinational next-position / bounce / miss evaluation for one tick.
// Ports: ball_i (current ball), step_i (px per tick), left/right paddle top y;
//        ball_c (next ball), miss_left_c / miss_right_c (ball left the field).
module pong_ball_collide
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W  = DFLT_SCREEN_W,
  parameter int unsigned SCREEN_H  = DFLT_SCREEN_H,
  parameter int unsigned BALL_SIZE = DFLT_BALL_SIZE,
  parameter int unsigned PADDLE_W  = DFLT_PADDLE_W,
  parameter int unsigned PADDLE_H  = DFLT_PADDLE_H,
  parameter int unsigned LEFT_X    = DFLT_LEFT_X,
  parameter int unsigned RIGHT_X   = DFLT_RIGHT_X
) (
  input  ball_t              ball_i,
  input  logic [STEP_W-1:0]  step_i,
  input  logic [POS_W-1:0]   left_pos_i,
  input  logic [POS_W-1:0]   right_pos_i,
  output ball_t              ball_c,
  output logic               miss_left_c,
  output logic               miss_right_c
);

  localparam logic signed [CALC_W-1:0] LEFT_EDGE  = CALC_W'(LEFT_X + PADDLE_W);
  localparam logic signed [CALC_W-1:0] RIGHT_EDGE = CALC_W'(RIGHT_X - BALL_SIZE);
  localparam logic signed [CALC_W-1:0] X_MAX      = CALC_W'(SCREEN_W - BALL_SIZE);
  localparam logic signed [CALC_W-1:0] Y_MAX      = CALC_W'(SCREEN_H - BALL_SIZE);

  logic signed [CALC_W-1:0] step_s;
  logic signed [CALC_W-1:0] x_s, y_s, nx_s, ny_s;
  logic        [CALC_W-1:0] ball_bot, lpad_bot, rpad_bot;
  logic                     left_hit, right_hit;

  always_comb begin
    step_s   = $signed(CALC_W'(step_i));
    x_s      = $signed({1'b0, ball_i.x});
    y_s      = $signed({1'b0, ball_i.y});
    nx_s     = ball_i.dx_neg ? (x_s - step_s) : (x_s + step_s);
    ny_s     = ball_i.dy_neg ? (y_s - step_s) : (y_s + step_s);
    // Unsigned sums; 12 bits hold an 11-bit paddle position plus its height.
    ball_bot = CALC_W'(ball_i.y) + CALC_W'(BALL_SIZE);
    lpad_bot = CALC_W'(left_pos_i) + CALC_W'(PADDLE_H);
    rpad_bot = CALC_W'(right_pos_i) + CALC_W'(PADDLE_H);

    // A paddle only deflects a ball that crosses its face during this step.
    left_hit  = ball_i.dx_neg && (x_s >= LEFT_EDGE) && (nx_s < LEFT_EDGE) &&
                (ball_bot > CALC_W'(left_pos_i)) && (CALC_W'(ball_i.y) < lpad_bot);
    right_hit = !ball_i.dx_neg && (x_s <= RIGHT_EDGE) && (nx_s > RIGHT_EDGE) &&
                (ball_bot > CALC_W'(right_pos_i)) && (CALC_W'(ball_i.y) < rpad_bot);

    ball_c       = ball_i;
    miss_left_c  = 1'b0;
    miss_right_c = 1'b0;

    // Vertical axis: walls clamp and reflect.
    if (ny_s[CALC_W-1]) begin
      ball_c.y      = '0;
      ball_c.dy_neg = 1'b0;
    end else if (ny_s > Y_MAX) begin
      ball_c.y      = POS_W'(Y_MAX);
      ball_c.dy_neg = 1'b1;
    end else begin
      ball_c.y = POS_W'(ny_s);
    end

    // Horizontal axis: paddle bounce wins over leaving the field.
    if (left_hit) begin
      ball_c.x      = POS_W'(LEFT_EDGE);
      ball_c.dx_neg = 1'b0;
    end else if (right_hit) begin
      ball_c.x      = POS_W'(RIGHT_EDGE);
      ball_c.dx_neg = 1'b1;
    end else if (nx_s[CALC_W-1]) begin
      miss_left_c = 1'b1;
    end else if (nx_s > X_MAX) begin
      miss_right_c = 1'b1;
    end else begin
      ball_c.x = POS_W'(nx_s);
    end
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: frame-ticked ball motion, paddle/wall bounces, scoring and
// game flow (IDLE -> SERVE -> MOVE -> GOAL -> SERVE/OVER).
// Ports: clk, rst (sync active-low), vs (frame marker), enable, serve,
//        speed_selector, left/right_palette_pos (paddle top y);
//        ball_xpos/ball_ypos, score {left,right} BCD, goal pulse, game_over.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W    = DFLT_SCREEN_W,
  parameter int unsigned SCREEN_H    = DFLT_SCREEN_H,
  parameter int unsigned BALL_SIZE   = DFLT_BALL_SIZE,
  parameter int unsigned PADDLE_W    = DFLT_PADDLE_W,
  parameter int unsigned PADDLE_H    = DFLT_PADDLE_H,
  parameter int unsigned LEFT_X      = DFLT_LEFT_X,
  parameter int unsigned RIGHT_X     = DFLT_RIGHT_X,
  parameter int unsigned WIN_SCORE   = DFLT_WIN_SCORE,
  parameter int unsigned GOAL_FRAMES = DFLT_GOAL_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             enable,
  input  logic             serve,
  input  logic [1:0]       speed_selector,
  input  logic [POS_W-1:0] left_palette_pos,
  input  logic [POS_W-1:0] right_palette_pos,
  output logic [POS_W-1:0] ball_xpos,
  output logic [POS_W-1:0] ball_ypos,
  output logic [7:0]       score,
  output logic             goal,
  output logic             game_over
);

  localparam int unsigned CNT_W = $clog2(GOAL_FRAMES + 1);
  localparam logic [POS_W-1:0] CENTER_X = POS_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0] CENTER_Y = POS_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam ball_t BALL_HOME = '{x: CENTER_X, y: CENTER_Y, dx_neg: 1'b0, dy_neg: 1'b0};

  state_e             state_q, state_d;
  ball_t              ball_q, ball_d, ball_nxt_c;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               goal_q, goal_d;
  logic               game_over_q, game_over_d;
  logic               vs_q, vs_d;
  logic               scored_left_q, scored_left_d;
  logic               adv_c, miss_left_c, miss_right_c;
  logic [STEP_W-1:0]  step_c;

  assign step_c = step_px(speed_selector);

  pong_ball_collide #(
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H),
    .BALL_SIZE (BALL_SIZE),
    .PADDLE_W  (PADDLE_W),
    .PADDLE_H  (PADDLE_H),
    .LEFT_X    (LEFT_X),
    .RIGHT_X   (RIGHT_X)
  ) u_collide (
    .ball_i       (ball_q),
    .step_i       (step_c),
    .left_pos_i   (left_palette_pos),
    .right_pos_i  (right_palette_pos),
    .ball_c       (ball_nxt_c),
    .miss_left_c  (miss_left_c),
    .miss_right_c (miss_right_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    ball_d        = ball_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    cnt_d         = cnt_q;
    scored_left_d = scored_left_q;
    goal_d        = 1'b0;
    vs_d          = vs;
    // Rising edge of vs, gated by enable, advances the game by one frame.
    adv_c         = vs && !vs_q && enable;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (serve) begin
          state_d   = ST_SERVE;
          ball_d    = BALL_HOME;
          score_l_d = '0;
          score_r_d = '0;
          cnt_d     = '0;
        end
      end
      ST_SERVE: begin
        // Launch only; the first motion happens on the following tick.
        if (serve) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (adv_c) begin
          if (miss_left_c || miss_right_c) begin
            goal_d   = 1'b1;
            state_d  = ST_GOAL;
            cnt_d    = '0;
            ball_d.x = CENTER_X;
            ball_d.y = CENTER_Y;
            if (miss_left_c) begin
              score_r_d     = bcd_sat_inc(score_r_q);
              scored_left_d = 1'b0;
            end else begin
              score_l_d     = bcd_sat_inc(score_l_q);
              scored_left_d = 1'b1;
            end
          end else begin
            ball_d = ball_nxt_c;
          end
        end
      end
      ST_GOAL: begin
        if (adv_c) begin
          if (cnt_q == CNT_W'(GOAL_FRAMES - 1)) begin
            cnt_d = '0;
            if ((score_l_q == SCORE_W'(WIN_SCORE)) || (score_r_q == SCORE_W'(WIN_SCORE))) begin
              state_d = ST_OVER;
            end else begin
              state_d       = ST_SERVE;
              // Serve toward the player who just scored.
              ball_d.dx_neg = scored_left_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      ball_q        <= BALL_HOME;
      score_l_q     <= '0;
      score_r_q     <= '0;
      cnt_q         <= '0;
      goal_q        <= 1'b0;
      game_over_q   <= 1'b0;
      vs_q          <= 1'b0;
      scored_left_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ball_q        <= ball_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      cnt_q         <= cnt_d;
      goal_q        <= goal_d;
      game_over_q   <= game_over_d;
      vs_q          <= vs_d;
      scored_left_q <= scored_left_d;
    end
  end

  assign ball_xpos = ball_q.x;
  assign ball_ypos = ball_q.y;
  assign score     = {score_l_q, score_r_q};
  assign goal      = goal_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: walks one long rally through wall and
// paddle bounces with hand-computed positions, then goal timing, reset and a
// complete game to 9.
module tb_pong_ball_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs;
  logic        enable;
  logic        serve;
  logic [1:0]  speed_selector;
  logic [10:0] left_palette_pos;
  logic [10:0] right_palette_pos;
  logic [10:0] ball_xpos;
  logic [10:0] ball_ypos;
  logic [7:0]  score;
  logic        goal;
  logic        game_over;

  int errors = 0;
  int checks = 0;

  pong_ball_engine dut (
    .clk               (clk),
    .rst               (rst),
    .vs                (vs),
    .enable            (enable),
    .serve             (serve),
    .speed_selector    (speed_selector),
    .left_palette_pos  (left_palette_pos),
    .right_palette_pos (right_palette_pos),
    .ball_xpos         (ball_xpos),
    .ball_ypos         (ball_ypos),
    .score             (score),
    .goal              (goal),
    .game_over         (game_over)
  );

  always #5 clk = ~clk;

  // One frame tick; returns on the negedge right after the updating edge.
  task automatic tick(input logic [1:0] spd);
    @(negedge clk);
    speed_selector = spd;
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
  endtask

  task automatic press_serve();
    @(negedge clk);
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; vs = 1'b0; serve = 1'b0; enable = 1'b1; speed_selector = 2'd0;
    left_palette_pos = 11'd250; right_palette_pos = 11'd640;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    checks++;
    if (ball_xpos !== 11'd504 || ball_ypos !== 11'd376) begin
      errors++; $display("FAIL reset_pos: got (%0d,%0d) want (504,376)", ball_xpos, ball_ypos);
    end
    checks++;
    if (score !== 8'h00) begin
      errors++; $display("FAIL reset_score: got %h want 00", score);
    end
    checks++;
    if (goal !== 1'b0 || game_over !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got goal=%b over=%b want 0 0", goal, game_over);
    end
    tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd504 || ball_ypos !== 11'd376) begin
      errors++; $display("FAIL idle_hold: got (%0d,%0d) want (504,376)", ball_xpos, ball_ypos);
    end
  endtask

  task automatic test_first_tick();
    press_serve();
    press_serve();
    tick(2'd0);
    checks++;
    if (ball_xpos !== 11'd506 || ball_ypos !== 11'd378) begin
      errors++; $display("FAIL first_tick: got (%0d,%0d) want (506,378)", ball_xpos, ball_ypos);
    end
  endtask

  task automatic test_pause();
    enable = 1'b0;
    repeat (10) tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd506 || ball_ypos !== 11'd378) begin
      errors++; $display("FAIL pause: got (%0d,%0d) want (506,378)", ball_xpos, ball_ypos);
    end
    enable = 1'b1;
  endtask

  task automatic test_walls();
    repeat (47) tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd882 || ball_ypos !== 11'd752) begin
      errors++; $display("FAIL bottom_wall: got (%0d,%0d) want (882,752)", ball_xpos, ball_ypos);
    end
    repeat (10) tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd960 || ball_ypos !== 11'd672) begin
      errors++; $display("FAIL right_paddle: got (%0d,%0d) want (960,672)", ball_xpos, ball_ypos);
    end
    repeat (83) tick(2'd3);
    tick(2'd2);
    checks++;
    if (ball_xpos !== 11'd290 || ball_ypos !== 11'd2) begin
      errors++; $display("FAIL near_top: got (%0d,%0d) want (290,2)", ball_xpos, ball_ypos);
    end
    tick(2'd1);
    checks++;
    if (ball_xpos !== 11'd286 || ball_ypos !== 11'd0) begin
      errors++; $display("FAIL top_wall: got (%0d,%0d) want (286,0)", ball_xpos, ball_ypos);
    end
    tick(2'd0);
    checks++;
    if (ball_xpos !== 11'd284 || ball_ypos !== 11'd2) begin
      errors++; $display("FAIL top_dir: got (%0d,%0d) want (284,2)", ball_xpos, ball_ypos);
    end
  endtask

  task automatic test_left_paddle();
    repeat (29) tick(2'd3);
    tick(2'd0);
    checks++;
    if (ball_xpos !== 11'd50 || ball_ypos !== 11'd236) begin
      errors++; $display("FAIL left_approach: got (%0d,%0d) want (50,236)", ball_xpos, ball_ypos);
    end
    tick(2'd1);
    checks++;
    if (ball_xpos !== 11'd48 || ball_ypos !== 11'd240) begin
      errors++; $display("FAIL left_hit: got (%0d,%0d) want (48,240)", ball_xpos, ball_ypos);
    end
    tick(2'd0);
    checks++;
    if (ball_xpos !== 11'd50 || ball_ypos !== 11'd242) begin
      errors++; $display("FAIL left_dir: got (%0d,%0d) want (50,242)", ball_xpos, ball_ypos);
    end
  endtask

  task automatic test_miss();
    right_palette_pos = 11'd300;
    repeat (64) tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd562 || ball_ypos !== 11'd752) begin
      errors++; $display("FAIL bottom2: got (%0d,%0d) want (562,752)", ball_xpos, ball_ypos);
    end
    repeat (50) tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd960 || ball_ypos !== 11'd352) begin
      errors++; $display("FAIL right_hit2: got (%0d,%0d) want (960,352)", ball_xpos, ball_ypos);
    end
    repeat (45) tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd600 || ball_ypos !== 11'd0) begin
      errors++; $display("FAIL top2: got (%0d,%0d) want (600,0)", ball_xpos, ball_ypos);
    end
    left_palette_pos = 11'd700;
    repeat (68) tick(2'd3);
    tick(2'd2);
    checks++;
    if (ball_xpos !== 11'd50 || ball_ypos !== 11'd550) begin
      errors++; $display("FAIL miss_approach: got (%0d,%0d) want (50,550)", ball_xpos, ball_ypos);
    end
    tick(2'd1);
    checks++;
    if (ball_xpos !== 11'd46 || ball_ypos !== 11'd554) begin
      errors++; $display("FAIL pass_paddle: got (%0d,%0d) want (46,554)", ball_xpos, ball_ypos);
    end
    repeat (11) tick(2'd1);
    checks++;
    if (ball_xpos !== 11'd2 || ball_ypos !== 11'd598 || goal !== 1'b0) begin
      errors++; $display("FAIL edge: got (%0d,%0d) goal=%b want (2,598) goal=0", ball_xpos, ball_ypos, goal);
    end
    tick(2'd1);
    checks++;
    if (goal !== 1'b1 || score !== 8'h01) begin
      errors++; $display("FAIL right_scores: got goal=%b score=%h want 1 01", goal, score);
    end
    checks++;
    if (ball_xpos !== 11'd504 || ball_ypos !== 11'd376) begin
      errors++; $display("FAIL goal_centre: got (%0d,%0d) want (504,376)", ball_xpos, ball_ypos);
    end
    @(negedge clk);
    checks++;
    if (goal !== 1'b0) begin
      errors++; $display("FAIL goal_pulse: got %b want 0 one cycle later", goal);
    end
  endtask

  task automatic test_goal_timing();
    repeat (59) tick(2'd0);
    checks++;
    if (ball_xpos !== 11'd504 || ball_ypos !== 11'd376 || game_over !== 1'b0) begin
      errors++; $display("FAIL goal_hold: got (%0d,%0d) over=%b want (504,376) 0", ball_xpos, ball_ypos, game_over);
    end
    press_serve();
    tick(2'd0);
    // Serve together with a tick: launches without moving.
    @(negedge clk);
    speed_selector = 2'd0; vs = 1'b1; serve = 1'b1;
    @(negedge clk);
    vs = 1'b0; serve = 1'b0;
    checks++;
    if (ball_xpos !== 11'd504 || ball_ypos !== 11'd376) begin
      errors++; $display("FAIL serve_tick: got (%0d,%0d) want (504,376)", ball_xpos, ball_ypos);
    end
    tick(2'd0);
    checks++;
    if (ball_xpos !== 11'd506) begin
      errors++; $display("FAIL serve_dir: got x=%0d want 506", ball_xpos);
    end
  endtask

  task automatic test_reset_mid_goal();
    left_palette_pos = 11'd1500; right_palette_pos = 11'd1500;
    repeat (62) tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd1002 || goal !== 1'b0) begin
      errors++; $display("FAIL right_edge: got x=%0d goal=%b want 1002 0", ball_xpos, goal);
    end
    tick(2'd3);
    checks++;
    if (goal !== 1'b1 || score !== 8'h11) begin
      errors++; $display("FAIL left_scores: got goal=%b score=%h want 1 11", goal, score);
    end
    repeat (5) tick(2'd3);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    checks++;
    if (ball_xpos !== 11'd504 || ball_ypos !== 11'd376 || score !== 8'h00 ||
        goal !== 1'b0 || game_over !== 1'b0) begin
      errors++; $display("FAIL reset_goal: got (%0d,%0d) score=%h goal=%b over=%b want (504,376) 00 0 0",
                         ball_xpos, ball_ypos, score, goal, game_over);
    end
    tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd504 || ball_ypos !== 11'd376) begin
      errors++; $display("FAIL reset_idle: got (%0d,%0d) want (504,376)", ball_xpos, ball_ypos);
    end
  endtask

  task automatic test_full_game();
    logic [3:0] exp_l, exp_r;
    int n;
    exp_l = 4'd0; exp_r = 4'd0;
    press_serve();
    for (int g = 0; g < 17; g++) begin
      press_serve();
      n = 0;
      while (goal !== 1'b1 && n < 100) begin
        tick(2'd3);
        n++;
      end
      if (g % 2 == 0) exp_l = exp_l + 4'd1;
      else            exp_r = exp_r + 4'd1;
      checks++;
      if (n != 64) begin
        errors++; $display("FAIL rally_len g=%0d: got %0d ticks want 64", g, n);
      end
      checks++;
      if (score !== {exp_l, exp_r}) begin
        errors++; $display("FAIL game_score g=%0d: got %h want %h", g, score, {exp_l, exp_r});
      end
      if (g < 16) repeat (60) tick(2'd0);
    end
    repeat (59) tick(2'd0);
    checks++;
    if (game_over !== 1'b0) begin
      errors++; $display("FAIL over_early: got %b want 0", game_over);
    end
    tick(2'd0);
    checks++;
    if (game_over !== 1'b1 || score !== 8'h98) begin
      errors++; $display("FAIL over: got over=%b score=%h want 1 98", game_over, score);
    end
    tick(2'd3);
    checks++;
    if (ball_xpos !== 11'd504 || ball_ypos !== 11'd376 || game_over !== 1'b1 || score !== 8'h98) begin
      errors++; $display("FAIL over_hold: got (%0d,%0d) over=%b score=%h want (504,376) 1 98",
                         ball_xpos, ball_ypos, game_over, score);
    end
    press_serve();
    checks++;
    if (score !== 8'h00 || game_over !== 1'b0) begin
      errors++; $display("FAIL new_game: got score=%h over=%b want 00 0", score, game_over);
    end
    press_serve();
    tick(2'd0);
    checks++;
    if (ball_xpos !== 11'd506 || ball_ypos !== 11'd378) begin
      errors++; $display("FAIL new_game_move: got (%0d,%0d) want (506,378)", ball_xpos, ball_ypos);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_pause();
    test_walls();
    test_left_paddle();
    test_miss();
    test_goal_timing();
    test_reset_mid_goal();
    test_full_game();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
